// File: rtl/send_pkg.sv
// Shared types and constants for the req/ack link sender.
// The optional ack timeout is enabled by defining SEND_ACK_TIMEOUT_EN.
package send_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } send_state_e;

    localparam int HS_4PHASE = 0;
    localparam int HS_2PHASE = 1;

    function automatic int entry_width(input int data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/send_reqack_tx_if.sv
// Stream-side and link-side signals of one send_reqack_tx port.
// The slave modport is the sender itself; the master modport is its environment.
interface send_reqack_tx_if #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0]   s_axis_tdata;
    logic                s_axis_tvalid;
    logic [DATA_W/8-1:0] s_axis_tkeep;
    logic                s_axis_tlast;
    logic                s_axis_tready;
    logic                tx_ack;
    logic                tx_req;
    logic [DATA_W-1:0]   tx_data;
    logic                send_done;
    logic [LVL_W-1:0]    fifo_level;
    logic                busy;
    logic                tx_err;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tkeep, s_axis_tlast, tx_ack,
        output s_axis_tready, tx_req, tx_data, send_done, fifo_level, busy, tx_err
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tkeep, s_axis_tlast, tx_ack,
        input  s_axis_tready, tx_req, tx_data, send_done, fifo_level, busy, tx_err
    );

endinterface

// File: rtl/send_sync_fifo.sv
// Generic synchronous FIFO with a registered head-of-queue word.
// Occupancy counts both the storage array and the output register.
module send_sync_fifo #(
    parameter  int WIDTH = 17,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [LVL_W-1:0] o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_mem_cnt;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             w_pop;
    logic             w_load;

    assign w_pop  = i_pop & r_out_valid;
    // Refill the head register whenever it is vacant or being consumed this cycle.
    assign w_load = (r_mem_cnt != '0) & (~r_out_valid | w_pop);

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_mem_cnt   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_load) begin
                r_out_data  <= r_mem[r_rd_ptr];
                r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
                r_out_valid <= 1'b1;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
            case ({i_push, w_load})
                2'b10:   r_mem_cnt <= r_mem_cnt + LVL_W'(1);
                2'b01:   r_mem_cnt <= r_mem_cnt - LVL_W'(1);
                default: r_mem_cnt <= r_mem_cnt;
            endcase
        end
    end

    assign o_rdata = r_out_data;
    assign o_empty = ~r_out_valid;
    assign o_level = r_mem_cnt + LVL_W'(r_out_valid);
    assign o_full  = (o_level == LVL_W'(DEPTH));

endmodule

// File: rtl/send_reqack_tx.sv
// Buffers an AXI-Stream beat stream and drains it word by word over a req/ack link.
// Define SEND_ACK_TIMEOUT_EN to bound ack waits and raise the sticky tx_err flag.
module send_reqack_tx
    import send_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int HS_MODE     = 0,
    parameter int ACK_TIMEOUT = 1024
) (
    input logic              clk,
    input logic              rst_n,
    send_reqack_tx_if.slave  bus
);

    localparam int ENTRY_W = entry_width(DATA_W);
    localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [ENTRY_W-1:0]     w_rdata;
    logic [LVL_W-1:0]       w_level;
    logic                   w_ack_s;
    logic                   w_progress;
    logic                   w_waiting;
    logic                   w_timeout;

    logic [SYNC_STAGES-1:0] r_ack_sync;
    send_state_e            r_state;
    logic                   r_tx_req;
    logic [DATA_W-1:0]      r_tx_data;
    logic                   r_last;
    logic                   r_send_done;

    // Beats with no enabled bytes are accepted but never stored.
    assign w_push = bus.s_axis_tvalid & bus.s_axis_tready & (|bus.s_axis_tkeep);
    assign w_pop  = (r_state == ST_IDLE) & ~w_empty;

    send_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata ({bus.s_axis_tlast, bus.s_axis_tdata}),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], bus.tx_ack};
        end
    end

    assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

    always_comb begin
        w_progress = 1'b0;
        case (r_state)
            ST_REQ:  w_progress = (HS_MODE == HS_2PHASE) ? (w_ack_s == r_tx_req) : w_ack_s;
            ST_REL:  w_progress = ~w_ack_s;
            default: w_progress = 1'b0;
        endcase
    end

    assign w_waiting = ((r_state == ST_REQ) | (r_state == ST_REL)) & ~w_progress;

`ifdef SEND_ACK_TIMEOUT_EN
    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

    logic [TO_W-1:0] r_wait_cnt;
    logic            r_tx_err;

    assign w_timeout = w_waiting & (r_wait_cnt == TO_W'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_tx_err   <= 1'b0;
        end else begin
            if (w_pop || ((r_state == ST_REQ) && w_progress)) begin
                r_wait_cnt <= '0;
            end else if (w_waiting) begin
                r_wait_cnt <= r_wait_cnt + TO_W'(1);
            end
            if (w_timeout) begin
                r_tx_err <= 1'b1;
            end
        end
    end

    assign bus.tx_err = r_tx_err;
`else
    assign w_timeout  = 1'b0;
    assign bus.tx_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_tx_req    <= 1'b0;
            r_tx_data   <= '0;
            r_last      <= 1'b0;
            r_send_done <= 1'b0;
        end else begin
            r_send_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_tx_data <= w_rdata[DATA_W-1:0];
                        r_last    <= w_rdata[DATA_W];
                        r_tx_req  <= (HS_MODE == HS_2PHASE) ? ~r_tx_req : 1'b1;
                        r_state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (w_progress) begin
                        if (HS_MODE == HS_2PHASE) begin
                            r_send_done <= r_last;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_tx_req <= 1'b0;
                            r_state  <= ST_REL;
                        end
                    end else if (w_timeout) begin
                        // Two-phase keeps its level; the next word toggles from here.
                        if (HS_MODE != HS_2PHASE) begin
                            r_tx_req <= 1'b0;
                        end
                        r_state <= ST_IDLE;
                    end
                end
                ST_REL: begin
                    if (w_progress) begin
                        r_send_done <= r_last;
                        r_state     <= ST_IDLE;
                    end else if (w_timeout) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.s_axis_tready = ~w_full;
    assign bus.tx_req        = r_tx_req;
    assign bus.tx_data       = r_tx_data;
    assign bus.send_done     = r_send_done;
    assign bus.fifo_level    = w_level;
    assign bus.busy          = (w_level != '0) | (r_state != ST_IDLE);

endmodule
